timer_req_scheduler: RTL and testbench
======================================

# timer_req_scheduler

Shares one 16-bit Avalon-MM interval timer among NREQ hardware requesters, such as the gesture frame-sample and debounce engines. The block round-robin arbitrates one-shot timeout requests and programs the timer's period and control registers through its slave port. It waits for the timer irq, clears the timer status, and returns a done pulse to the winning requester. Software no longer services the timer for these requesters; the timer sits behind this block, not on the CPU bus.

## Interface
- NREQ, 4: number of requesters, 2..8
- IDW, 3: width of grant_id, ≥ clog2(NREQ)
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  level request per requester; held until done/aborted
- period  in  NREQ*32  timeout length per requester, slice i = period[32*i+31:32*i]
- done  out  NREQ  one-cycle pulse, timeout expired for requester i
- aborted  out  NREQ  one-cycle pulse, requester i withdrew before expiry
- busy  out  1  timer owned by a requester (any state except IDLE)
- grant_id  out  IDW  index of current or last owner
- tmr_address  out  3  timer register select
- tmr_chipselect  out  1  timer chip select
- tmr_write_n  out  1  timer write strobe, active-low
- tmr_writedata  out  16  timer write data
- tmr_irq  in  1  timer interrupt, level, cleared by status write

## Operation
- Timer map: 0 status (write clears timeout), 1 control, 2 period_l, 3 period_h.
  - Control bits: ITO = bit0, CONT = bit1, START = bit2, STOP = bit3.
- Each timer write is exactly one cycle: chipselect=1, write_n=0. The slave has zero wait states and the block never reads the timer.
- FSM states: IDLE, ARB, WR_PL, WR_PH, SETTLE, WR_CTRL, WAIT, STOP, CLR.
- IDLE → ARB when any req bit is set.
- ARB: round-robin pick, searching upward from (last grant + 1) mod NREQ.
  - Latch g and period[g] into p.
  - If p == 0: pulse done[g] in ARB and return to IDLE with no timer access.
  - Otherwise go to WR_PL.
- WR_PL writes p[15:0] to address 2. WR_PH writes p[31:16] to address 3.
- SETTLE is a one-cycle gap with no write; it lets the timer's force_reload clear.
- WR_CTRL writes 0x0005 (ITO|START, CONT=0) to address 1, then moves to WAIT.
- WAIT has three exits:
  - tmr_irq=1 → CLR with outcome done.
  - Otherwise req[g]=0 → STOP with outcome aborted.
  - Otherwise stay in WAIT.
  - irq takes priority over req=0 in the same cycle.
- STOP writes 0x0008 (STOP, ITO=0) to address 1, then moves to CLR.
- CLR writes 0x0000 to address 0, pulses done[g] or aborted[g], then moves to IDLE.
- Period p produces a timer expiry p+1 cycles after the WR_CTRL write, per the timer's count-to-zero reload.
- period is sampled only in ARB. Changes to it while granted are ignored.
- Requests from other requesters are queued as long as they stay asserted. Deasserting req while not granted has no effect.
- A requester whose req is still high in the cycle after its done/aborted pulse is treated as a new request.
- Reset mid-operation puts the FSM in IDLE and all outputs at reset values. The timer is reset by the same reset_n.

## Timing
- Reset values:
  - tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0.
  - done=0, aborted=0, busy=0, grant_id=0.
  - Round-robin pointer set so requester 0 has first priority.
- All outputs are registered or decoded from the registered state.
- Latencies:
  - req rising in IDLE (cycle 0) → ARB at cycle 1 → WR_PL at 2, WR_PH at 3, SETTLE at 4, WR_CTRL at 5.
  - irq sampled high in WAIT at cycle k → CLR write and done pulse at k+1 → IDLE at k+2.
  - Back-to-back grants: next ARB is at k+3.
  - Abort: req low sampled at k → STOP at k+1, CLR and aborted pulse at k+2.
- Only one timer access per cycle. No access in IDLE, ARB, SETTLE or WAIT.

## Structure
- Package timer_sched_pkg holds:
  - state enum;
  - timer register address constants;
  - control values CTRL_ONESHOT=16'h0005 and CTRL_STOP=16'h0008.
- Sub-module rr_arbiter(NREQ): one-hot grant from req and a last-grant pointer.
  - The pointer updates only on the ARB cycle.

## Test plan
- Single request: req[1]=1, period=0x00000010.
  - Writes in order: addr2=0x0010, addr3=0x0000, SETTLE gap, addr1=0x0005.
  - Timer model raises irq 17 cycles after the control write.
  - Expect addr0 write and done[1] pulse one cycle after irq, and grant_id=1.
- Round-robin: req=4'b1011 held with equal periods.
  - Grant order 0,1,3,0 (requester 0 re-asserting), with no starvation.
- Abort: req[2] deasserted 5 cycles into WAIT.
  - Expect addr1=0x0008, then addr0=0x0000, then aborted[2]=1 and done[2]=0.
- Race: irq and req[g] deassert in the same WAIT cycle.
  - Expect done[g]=1, aborted=0, and no STOP write.
- Zero period: req[3]=1, period=0.
  - Expect done[3] pulse in the ARB cycle and no tmr_chipselect activity.
- Reset mid-WAIT: reset_n low for 2 cycles.
  - Expect all outputs at reset values.
  - After release with req[0]=1, expect a full sequence beginning at cycle 1.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer request scheduler.
// Register map and control words match the Avalon-MM interval timer slave.
package timer_sched_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StArb,
        StWrPl,
        StWrPh,
        StSettle,
        StWrCtrl,
        StWait,
        StStop,
        StClr
    } state_e;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

    localparam logic [15:0] CTRL_ONESHOT = 16'h0005;
    localparam logic [15:0] CTRL_STOP    = 16'h0008;

endpackage

// File: rtl/timer_req_scheduler_if.sv
// Write-only Avalon-MM link from the scheduler to the interval timer, plus its irq.
interface timer_req_scheduler_if;

    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_irq
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from (last + 1) mod NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    int last_i;

    // Lowest requester above last wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        last_i  = 32'(last);
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[i] && i <= last_i) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[i] && i > last_i) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/timer_req_scheduler.sv
// Arbitrates one-shot timeout requests onto a single shared interval timer,
// programs it, waits for its irq, clears it and reports done/aborted per requester.
module timer_req_scheduler
    import timer_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*32-1:0]    period,
    output logic [NREQ-1:0]       done,
    output logic [NREQ-1:0]       aborted,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    timer_req_scheduler_if.master tmr
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  gidx_q, gidx_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [NREQ-1:0] goh_q, goh_d;
    logic [31:0]     p_q, p_d;
    logic            abort_q, abort_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic [31:0]     arb_period;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req),
        .last    (last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        arb_period = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (arb_gnt[i]) arb_period = period[32*i +: 32];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            gidx_q  <= '0;
            last_q  <= IDW'(NREQ - 1);
            goh_q   <= '0;
            p_q     <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            goh_q   <= goh_d;
            p_q     <= p_d;
            abort_q <= abort_d;
        end
    end

    // Winner and its period are captured on entry to ARB so that every output in
    // ARB, including the zero-period done pulse, comes straight from registers.
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        goh_d   = goh_q;
        p_d     = p_q;
        abort_d = abort_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StArb;
                    gidx_d  = arb_idx;
                    goh_d   = arb_gnt;
                    p_d     = arb_period;
                end
            end
            StArb: begin
                last_d  = gidx_q;
                abort_d = 1'b0;
                state_d = (p_q == '0) ? StIdle : StWrPl;
            end
            StWrPl:   state_d = StWrPh;
            StWrPh:   state_d = StSettle;
            StSettle: state_d = StWrCtrl;
            StWrCtrl: state_d = StWait;
            StWait: begin
                if (tmr.tmr_irq) begin
                    state_d = StClr;
                    abort_d = 1'b0;
                end else if ((req & goh_q) == '0) begin
                    state_d = StStop;
                    abort_d = 1'b1;
                end
            end
            StStop:   state_d = StClr;
            StClr:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        done               = '0;
        aborted            = '0;
        tmr.tmr_chipselect = 1'b0;
        tmr.tmr_write_n    = 1'b1;
        tmr.tmr_address    = '0;
        tmr.tmr_writedata  = '0;
        case (state_q)
            StArb: begin
                if (p_q == '0) done = goh_q;
            end
            StWrPl: begin
                tmr.tmr_chipselect = 1'b1;
                tmr.tmr_write_n    = 1'b0;
                tmr.tmr_address    = ADDR_PERIOD_L;
                tmr.tmr_writedata  = p_q[15:0];
            end
            StWrPh: begin
                tmr.tmr_chipselect = 1'b1;
                tmr.tmr_write_n    = 1'b0;
                tmr.tmr_address    = ADDR_PERIOD_H;
                tmr.tmr_writedata  = p_q[31:16];
            end
            StWrCtrl: begin
                tmr.tmr_chipselect = 1'b1;
                tmr.tmr_write_n    = 1'b0;
                tmr.tmr_address    = ADDR_CONTROL;
                tmr.tmr_writedata  = CTRL_ONESHOT;
            end
            StStop: begin
                tmr.tmr_chipselect = 1'b1;
                tmr.tmr_write_n    = 1'b0;
                tmr.tmr_address    = ADDR_CONTROL;
                tmr.tmr_writedata  = CTRL_STOP;
            end
            StClr: begin
                tmr.tmr_chipselect = 1'b1;
                tmr.tmr_write_n    = 1'b0;
                tmr.tmr_address    = ADDR_STATUS;
                tmr.tmr_writedata  = 16'h0000;
                if (abort_q) aborted = goh_q;
                else         done    = goh_q;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign grant_id = gidx_q;

endmodule

// File: tb/tb_timer_req_scheduler.sv
// Self-checking bench: timer model plus an event scoreboard of timer writes and
// done/aborted pulses, each tagged with the cycle it appeared in.
module tb_timer_req_scheduler;
    import timer_sched_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 3;

    typedef struct packed {
        logic [1:0]  kind;  // 0 write, 1 done, 2 aborted
        logic [2:0]  idx;   // write address or requester index
        logic [15:0] data;  // write data or grant_id
        logic [31:0] cyc;
    } ev_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*32-1:0]  period = '0;
    logic [NREQ-1:0]     done;
    logic [NREQ-1:0]     aborted;
    logic                busy;
    logic [IDW-1:0]      grant_id;

    timer_req_scheduler_if tmr ();

    timer_req_scheduler #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .period   (period),
        .done     (done),
        .aborted  (aborted),
        .busy     (busy),
        .grant_id (grant_id),
        .tmr      (tmr)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Timer model: irq rises p+1 cycles after a START control write.
    logic [31:0] t_per;
    int          t_cnt;
    logic        t_run;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr.tmr_irq <= 1'b0;
            t_per       <= '0;
            t_cnt       <= 0;
            t_run       <= 1'b0;
        end else begin
            if (t_run) begin
                if (t_cnt == 0) begin
                    tmr.tmr_irq <= 1'b1;
                    t_run       <= 1'b0;
                end else begin
                    t_cnt <= t_cnt - 1;
                end
            end
            if (tmr.tmr_chipselect && !tmr.tmr_write_n) begin
                case (tmr.tmr_address)
                    3'd0: tmr.tmr_irq <= 1'b0;
                    3'd1: begin
                        if (tmr.tmr_writedata[3]) begin
                            t_run <= 1'b0;
                        end else if (tmr.tmr_writedata[2]) begin
                            t_run <= 1'b1;
                            t_cnt <= int'(t_per) - 1;
                        end
                    end
                    3'd2: t_per[15:0]  <= tmr.tmr_writedata;
                    3'd3: t_per[31:16] <= tmr.tmr_writedata;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (tmr.tmr_chipselect && !tmr.tmr_write_n)
                obs_q.push_back('{2'd0, tmr.tmr_address, tmr.tmr_writedata, 32'(cyc)});
            for (int i = 0; i < int'(NREQ); i++) begin
                if (done[i])    obs_q.push_back('{2'd1, 3'(i), 16'(grant_id), 32'(cyc)});
                if (aborted[i]) obs_q.push_back('{2'd2, 3'(i), 16'(grant_id), 32'(cyc)});
            end
        end
    end

    task automatic push_ev(input int kind, input int a, input int d, input int c);
        exp_q.push_back('{2'(kind), 3'(a), 16'(d), 32'(c)});
    endtask

    task automatic push_prog(input int a, input int p);
        push_ev(0, 2, p & 32'hffff, a + 1);
        push_ev(0, 3, (p >> 16) & 32'hffff, a + 2);
        push_ev(0, 1, 5, a + 4);
    endtask

    // Full normal grant starting with ARB at cycle a.
    task automatic exp_grant(input int a, input int g, input int p);
        push_prog(a, p);
        push_ev(0, 0, 0, a + p + 6);
        push_ev(1, g, g, a + p + 6);
    endtask

    task automatic set_period(input int idx, input logic [31:0] v);
        period[32*idx +: 32] = v;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req     = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if (tmr.tmr_chipselect !== 1'b0) $display("FAIL reset cs: got %b want 0", tmr.tmr_chipselect);
        else n_pass++;
        n_checks++;
        if (tmr.tmr_write_n !== 1'b1) $display("FAIL reset write_n: got %b want 1", tmr.tmr_write_n);
        else n_pass++;
        n_checks++;
        if (done !== '0 || aborted !== '0)
            $display("FAIL reset pulses: got %b/%b want 0/0", done, aborted);
        else n_pass++;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== 0 || busy !== 1'b0)
            $display("FAIL reset idle: got %0d events busy %b want 0 events busy 0", obs_q.size(), busy);
        else n_pass++;
    endtask

    task automatic test_single();
        int a;
        ev_t e, o;
        apply_reset();
        set_period(1, 32'h0000_0010);
        a = cyc + 1;
        req = 4'b0010;
        exp_grant(a, 1, 16);
        wait_cyc(a + 1);
        set_period(1, 32'h0000_0007);  // must be ignored while granted
        wait_cyc(a + 22);
        req = '0;
        wait_cyc(a + 30);
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL single count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL single event: got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        int a;
        int order[4] = '{0, 1, 3, 0};
        ev_t e, o;
        apply_reset();
        for (int i = 0; i < int'(NREQ); i++) set_period(i, 32'd3);
        a = cyc + 1;
        req = 4'b1011;
        for (int j = 0; j < 4; j++) exp_grant(a + j * 11, order[j], 3);
        wait_cyc(a + 42);
        req = '0;
        wait_cyc(a + 50);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rr busy: got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL rr count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL rr event: got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        int a, k;
        ev_t e, o;
        apply_reset();
        set_period(2, 32'd100);
        a = cyc + 1;
        req = 4'b0100;
        k = a + 10;
        push_prog(a, 100);
        push_ev(0, 1, 8, k + 1);
        push_ev(0, 0, 0, k + 2);
        push_ev(2, 2, 2, k + 2);
        wait_cyc(k);
        req = '0;
        wait_cyc(k + 10);
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL abort count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL abort event: got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_race();
        int a;
        ev_t e, o;
        apply_reset();
        set_period(1, 32'd4);
        a = cyc + 1;
        req = 4'b0010;
        exp_grant(a, 1, 4);
        wait_cyc(a + 9);
        n_checks++;
        if (tmr.tmr_irq !== 1'b1) $display("FAIL race irq: got %b want 1", tmr.tmr_irq);
        else n_pass++;
        req = '0;
        wait_cyc(a + 16);
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL race count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL race event: got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_zero_period();
        int a;
        ev_t e, o;
        apply_reset();
        set_period(3, 32'd0);
        a = cyc + 1;
        req = 4'b1000;
        push_ev(1, 3, 3, a);
        wait_cyc(a);
        req = '0;
        wait_cyc(a + 8);
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL zero count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL zero event: got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_wait();
        int a, a2;
        ev_t e, o;
        apply_reset();
        set_period(2, 32'd50);
        a = cyc + 1;
        req = 4'b0100;
        push_prog(a, 50);
        wait_cyc(a + 8);
        n_checks++;
        if (busy !== 1'b1 || grant_id !== 3'd2)
            $display("FAIL midwait owner: got busy %b id %0d want busy 1 id 2", busy, grant_id);
        else n_pass++;
        reset_n = 1'b0;
        req = 4'b0001;
        set_period(0, 32'd3);
        @(negedge clk);
        n_checks++;
        if (tmr.tmr_chipselect !== 1'b0) $display("FAIL rst cs: got %b want 0", tmr.tmr_chipselect);
        else n_pass++;
        n_checks++;
        if (tmr.tmr_write_n !== 1'b1) $display("FAIL rst write_n: got %b want 1", tmr.tmr_write_n);
        else n_pass++;
        n_checks++;
        if (tmr.tmr_address !== 3'd0) $display("FAIL rst addr: got %0d want 0", tmr.tmr_address);
        else n_pass++;
        n_checks++;
        if (tmr.tmr_writedata !== 16'h0) $display("FAIL rst wdata: got %h want 0000", tmr.tmr_writedata);
        else n_pass++;
        n_checks++;
        if (done !== '0) $display("FAIL rst done: got %b want 0000", done);
        else n_pass++;
        n_checks++;
        if (aborted !== '0) $display("FAIL rst aborted: got %b want 0000", aborted);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rst busy: got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if (grant_id !== 3'd0) $display("FAIL rst grant_id: got %0d want 0", grant_id);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        a2 = cyc + 1;
        exp_grant(a2, 0, 3);
        wait_cyc(a2 + 9);
        req = '0;
        wait_cyc(a2 + 16);
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL rstwait count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL rstwait event: got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_race();
        test_zero_period();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
